// File: rtl/xc_sync_fifo_rd_stream.sv
// xc_sync_fifo_rd_stream
// Read-side adapter for the standard synchronous FIFO. It drains the FIFO
// through its rd/ne/data port and presents the words as a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so the
// adapter sustains one word per cycle under continuous ready.
// Optional feature macro: XC_SYNC_FIFO_RD_STREAM_STAT_EN (delivered-word counter).
module xc_sync_fifo_rd_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             fifo_ne_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_rd_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             idle_o,
  output logic [31:0]      beat_cnt_o
);

  logic [1:0]       occ_q, occ_d;
  logic             infl_q, infl_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic             pop;
  logic             push;
  logic [2:0]       occSum;

  // Stream outputs come straight from registers so nothing downstream sees an input-to-valid path.
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = head_q;
  assign idle_o    = (occ_q == 2'd0) & ~infl_q;

  // Read issue: only read when the word can be buffered after this cycle's pop; ready feeds rd combinationally for full rate.
  always_comb begin
    pop       = m_valid_o & m_ready_i;
    push      = infl_q;
    occSum    = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    fifo_rd_o = ~rst_i & en_i & fifo_ne_i & ~clr_i & (occSum < 3'd2);
  end

  // Skid buffer next state: a landing word goes to the first free slot, a pop shifts the second entry forward.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    infl_d = fifo_rd_o;
    if (clr_i) begin
      occ_d  = 2'd0;
      infl_d = 1'b0;
      head_d = '0;
      tail_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_d = fifo_data_i;
          end else begin
            tail_d = fifo_data_i;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = fifo_data_i;
          end else begin
            head_d = fifo_data_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State registers; the async reset also discards any word still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      infl_q <= infl_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef XC_SYNC_FIFO_RD_STREAM_STAT_EN
  logic [31:0] cnt_q, cnt_d;

  // Beat counter next state: one per delivered word, wrapping naturally; flush clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (pop) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt_o = cnt_q;
`else
  assign beat_cnt_o = 32'd0;
`endif

`ifndef SYNTHESIS
  // The read guard must make a push into a full buffer without a pop impossible.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (occ_q == 2'd2)));

  // Buffered plus in-flight words can never exceed the two slots.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (({1'b0, occ_q} + {2'b00, infl_q}) <= 3'd2));
`endif

endmodule
